// File: rtl/data_reg_stage.sv
// data_reg_stage: NCH x W-bit beat register with valid/ready handshake.
// Two-entry skid buffer (main drives dout, skid catches the in-flight beat)
// so in_ready can stay registered while sustaining one beat per cycle.
// All state changes on the falling edge of clk; rst and flush are synchronous.
// Optional macro DR_STALL_CNT_EN adds the saturating stall_cnt output.
module data_reg_stage #(
    parameter int W     = 32,
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NCH*W-1:0]   din,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NCH*W-1:0]   dout
`ifdef DR_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    if (W < 1) begin : g_bad_w
        $error("data_reg_stage: W must be >= 1");
    end
    if (NCH < 1) begin : g_bad_nch
        $error("data_reg_stage: NCH must be >= 1");
    end
    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("data_reg_stage: CNT_W must be >= 2");
    end

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [NCH*W-1:0]   main_q;
    logic [NCH*W-1:0]   skid_q;
    logic               acc;
    logic               dq;
    logic               ld_main_din;
    logic               ld_main_skid;
    logic               ld_skid;

    assign out_valid = (state != S_EMPTY);
    assign in_ready  = (state != S_FULL) && !flush && !rst;
    assign dout      = main_q;
    assign acc       = in_valid && in_ready;
    assign dq        = out_valid && out_ready;

    // Next state and data-register load selects; flush overrides any dequeue
    always_comb begin
        state_nx     = state;
        ld_main_din  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nx = S_EMPTY;
        end else begin
            unique case (state)
                S_EMPTY: begin
                    if (acc) begin
                        state_nx    = S_ONE;
                        ld_main_din = 1'b1;
                    end
                end
                S_ONE: begin
                    if (acc && dq) begin
                        ld_main_din = 1'b1;
                    end else if (acc) begin
                        state_nx = S_FULL;
                        ld_skid  = 1'b1;
                    end else if (dq) begin
                        state_nx = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (dq) begin
                        state_nx     = S_ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_nx = S_EMPTY;
            endcase
        end
    end

    // State and data registers, updated on the falling edge
    always_ff @(negedge clk) begin
        if (rst) begin
            state  <= S_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nx;
            if (ld_main_din) begin
                main_q <= din;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= din;
            end
        end
    end

`ifdef DR_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles where a held beat is refused downstream
    always_ff @(negedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_q != '1)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_data_reg_stage.sv
// Testbench for data_reg_stage: directed scenarios with literal expectations
// plus a long randomized run checked every cycle against a queue model.
`timescale 1ns/1ps
module tb_data_reg_stage;

    localparam int W     = 32;
    localparam int NCH   = 2;
    localparam int CNT_W = 2;
    localparam int DW    = NCH * W;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   din;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   dout;
`ifdef DR_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    data_reg_stage #(
        .W     (W),
        .NCH   (NCH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout)
`ifdef DR_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: ordered queue of held beats (at most two), the last
    // head value for dout while empty, and a saturating stall count.
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_head = '0;
    int unsigned   m_stall   = 0;
    bit            model_on  = 1'b0;

    always @(negedge clk) begin
        bit m_acc;
        bit m_dq;
        if (rst) begin
            q.delete();
            last_head = '0;
            m_stall   = 0;
            model_on  = 1'b1;
        end else if (model_on) begin
            if (flush) begin
                q.delete();
            end else begin
                m_acc = in_valid && (q.size() < 2);
                m_dq  = out_ready && (q.size() > 0);
                if ((q.size() > 0) && !out_ready && (m_stall < (2 ** CNT_W) - 1))
                    m_stall++;
                if (m_dq) void'(q.pop_front());
                if (m_acc) q.push_back(din);
                if (q.size() > 0) last_head = q[0];
            end
        end
    end

    // Every-cycle comparison, sampled mid-cycle away from the falling edge
    always @(posedge clk) begin
        if (model_on) begin
            chk("m_in_ready", DW'(in_ready), DW'((q.size() < 2) && !flush && !rst));
            chk("m_out_valid", DW'(out_valid), DW'(q.size() > 0));
            chk("m_dout", dout, last_head);
`ifdef DR_STALL_CNT_EN
            chk("m_stall_cnt", DW'(stall_cnt), DW'(m_stall));
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic at_pos();
        @(posedge clk);
    endtask

    function automatic logic [DW-1:0] beat(input int unsigned k);
        logic [W-1:0] v;
        v = W'(k);
        return {v, ~v};
    endfunction

    localparam logic [DW-1:0] A = 64'hA000_0001_5FFF_FFFE;
    localparam logic [DW-1:0] B = 64'hB000_0002_4FFF_FFFD;
    localparam logic [DW-1:0] C = 64'hC000_0003_3FFF_FFFC;
    localparam logic [DW-1:0] D = 64'hD000_0004_2FFF_FFFB;
    localparam logic [DW-1:0] E = 64'hE000_0005_1FFF_FFFA;
    localparam logic [DW-1:0] F = 64'hF000_0006_0FFF_FFF9;
    localparam logic [DW-1:0] G = 64'h1234_5678_9ABC_DEF0;

    initial begin
        // Reset with a beat offered: nothing may be taken
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; din = '1; out_ready = 1'b0;
        at_pos();
        chk("rst_in_ready_low", DW'(in_ready), '0);
        tick();
        rst = 1'b0; in_valid = 1'b0;
        at_pos();
        chk("rst_out_valid", DW'(out_valid), '0);
        chk("rst_dout", dout, '0);
        chk("rst_in_ready_after", DW'(in_ready), DW'(1));

        // Back-to-back stream, one-edge latency
        out_ready = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            din = beat(k);
            at_pos();
            chk("stream_in_ready", DW'(in_ready), DW'(1));
            if (k > 0) chk("stream_dout", dout, beat(k - 1));
            tick();
        end
        in_valid = 1'b0;
        at_pos();
        chk("stream_last", dout, 64'h0000_0007_FFFF_FFF8);
        tick();
        at_pos();
        chk("stream_drained", DW'(out_valid), '0);

        // Backpressure: A held, B in skid, C stalled, then all drain in order
        tick();
        out_ready = 1'b0; in_valid = 1'b1; din = A;
        tick();
        din = B;
        at_pos();
        chk("bp_a_held", dout, A);
        chk("bp_ready_for_b", DW'(in_ready), DW'(1));
        tick();
        din = C;
        at_pos();
        chk("bp_full_ready", DW'(in_ready), '0);
        chk("bp_full_dout", dout, A);
        tick();
        out_ready = 1'b1;
        at_pos();
        chk("bp_still_a", dout, A);
        tick();
        at_pos();
        chk("bp_b_out", dout, B);
        chk("bp_c_ready", DW'(in_ready), DW'(1));
        tick();
        in_valid = 1'b0;
        at_pos();
        chk("bp_c_out", dout, C);
        tick();
        at_pos();
        chk("bp_empty", DW'(out_valid), '0);

        // Flush while full with a beat offered
        tick();
        out_ready = 1'b0; in_valid = 1'b1; din = D;
        tick();
        din = E;
        tick();
        din = F; flush = 1'b1;
        at_pos();
        chk("fl_ready_low", DW'(in_ready), '0);
        tick();
        flush = 1'b0; din = G;
        at_pos();
        chk("fl_out_valid", DW'(out_valid), '0);
        chk("fl_in_ready", DW'(in_ready), DW'(1));
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        at_pos();
        chk("fl_next_beat", dout, G);
        chk("fl_next_valid", DW'(out_valid), DW'(1));
        tick();

`ifdef DR_STALL_CNT_EN
        begin
            int unsigned exp_st[6] = '{1, 2, 3, 3, 3, 3};
            rst = 1'b1;
            tick();
            rst = 1'b0; in_valid = 1'b1; din = A; out_ready = 1'b0;
            at_pos();
            chk("st_reset", DW'(stall_cnt), '0);
            tick();
            in_valid = 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                tick();
                at_pos();
                chk("st_count", DW'(stall_cnt), DW'(exp_st[i]));
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
            at_pos();
            chk("st_cleared", DW'(stall_cnt), '0);
            tick();
        end
`endif

        // Randomized traffic, checked each cycle by the model
        for (int unsigned n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 511) == 0);
            din       = {$urandom, $urandom};
            tick();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
